lzw_dict_ctrl: RTL and testbench

Dictionary controller for the LZW accelerator. It accepts read, insert and clear requests over a valid/ready interface and allocates dictionary codes. It sequences the single-port synchronous dictionary RAM through its cs/we/oe pins and shared tristate data bus. It sits directly upstream of the RAM; the encoder/decoder cores are its only clients.

---
 rtl/lzw_pkg.sv | 30 +++
 rtl/lzw_dict_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_lzw_dict_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/lzw_pkg.sv
// Shared types and default geometry for the LZW dictionary controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lzw_pkg;

    localparam int LZW_ADDR_WIDTH = 12;
    localparam int LZW_DATA_WIDTH = 20;
    localparam int LZW_CHAR_WIDTH = 8;
    localparam int LZW_DEPTH      = 4096;
    localparam int LZW_FIRST_CODE = 256;

    // Request opcodes as carried on req_op
    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_INSERT = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_RSVD   = 2'b11
    } lzw_op_e;

    // Controller FSM states; ST_INIT only reachable with LZW_DICT_INIT_EN
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_ISSUE   = 3'd1,
        ST_RD_CAPTURE = 3'd2,
        ST_WR         = 3'd3,
        ST_RSP        = 3'd4,
        ST_INIT       = 3'd5
    } lzw_state_e;

endpackage

// File: rtl/lzw_dict_ctrl.sv
// LZW dictionary controller: code allocation plus cs/we/oe sequencing of a sync single-port RAM.
// Latency: accept->rsp_valid 1 cycle (bypass/error/clear), 2 (insert), 3 (RAM read).
// Backpressure: req_ready only in IDLE; response held until rsp_ready. LZW_DICT_INIT_EN preloads literals after reset.
module lzw_dict_ctrl
    import lzw_pkg::*;
#(
    parameter int ADDR_WIDTH = LZW_ADDR_WIDTH,
    parameter int DATA_WIDTH = LZW_DATA_WIDTH,
    parameter int CHAR_WIDTH = LZW_CHAR_WIDTH,
    parameter int DEPTH      = LZW_DEPTH,
    parameter int FIRST_CODE = LZW_FIRST_CODE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_code,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] rsp_code,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH:0]   next_code,
    output logic                  dict_full,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    localparam int PREFIX_W = DATA_WIDTH - CHAR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FIRST_CODE_W = FIRST_CODE[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] DEPTH_W      = DEPTH[ADDR_WIDTH:0];

    lzw_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] code_q, code_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [ADDR_WIDTH-1:0] rsp_code_q, rsp_code_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [ADDR_WIDTH:0]   next_code_q, next_code_d;

    logic                  cs_c, we_c, oe_c, drv_c;
    logic [ADDR_WIDTH-1:0] addr_c;
    logic [DATA_WIDTH-1:0] drv_dat_c;
    logic                  full_c;

`ifdef LZW_DICT_INIT_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_INIT = ADDR_WIDTH'(FIRST_CODE - 1);
    localparam lzw_state_e RST_STATE = ST_INIT;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
`else
    localparam lzw_state_e RST_STATE = ST_IDLE;
`endif

    assign full_c = (next_code_q == DEPTH_W);

    // Next-state, response capture and RAM pin decode
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        wdat_d      = wdat_q;
        rsp_code_d  = rsp_code_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        next_code_d = next_code_q;
        cs_c        = 1'b0;
        we_c        = 1'b0;
        oe_c        = 1'b0;
        drv_c       = 1'b0;
        addr_c      = '0;
        drv_dat_c   = '0;
`ifdef LZW_DICT_INIT_EN
        init_cnt_d  = init_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    code_d     = req_code;
                    wdat_d     = req_data;
                    rsp_code_d = '0;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RSP;
                    case (lzw_op_e'(req_op))
                        OP_READ: begin
                            rsp_code_d = req_code;
`ifdef LZW_DICT_INIT_EN
                            // Literals live in the preloaded RAM
                            if ({1'b0, req_code} >= next_code_q) begin
                                rsp_err_d = 1'b1;
                            end else begin
                                state_d = ST_RD_ISSUE;
                            end
`else
                            // Literals never touch the RAM; synthesize the entry
                            if ({1'b0, req_code} < FIRST_CODE_W) begin
                                rsp_data_d = {{PREFIX_W{1'b1}}, req_code[CHAR_WIDTH-1:0]};
                            end else if ({1'b0, req_code} >= next_code_q) begin
                                rsp_err_d = 1'b1;
                            end else begin
                                state_d = ST_RD_ISSUE;
                            end
`endif
                        end
                        OP_INSERT: begin
                            if (full_c) begin
                                rsp_err_d = 1'b1;
                            end else begin
                                rsp_code_d = next_code_q[ADDR_WIDTH-1:0];
                                state_d    = ST_WR;
                            end
                        end
                        OP_CLEAR: begin
                            // Only the allocator rewinds; stale RAM contents are unreachable
                            next_code_d = FIRST_CODE_W;
                        end
                        default: begin
                            rsp_err_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_RD_ISSUE: begin
                cs_c    = 1'b1;
                addr_c  = code_q;
                state_d = ST_RD_CAPTURE;
            end
            ST_RD_CAPTURE: begin
                cs_c       = 1'b1;
                oe_c       = 1'b1;
                addr_c     = code_q;
                rsp_data_d = ram_data;
                state_d    = ST_RSP;
            end
            ST_WR: begin
                cs_c        = 1'b1;
                we_c        = 1'b1;
                drv_c       = 1'b1;
                addr_c      = next_code_q[ADDR_WIDTH-1:0];
                drv_dat_c   = wdat_q;
                next_code_d = next_code_q + 1'b1;
                state_d     = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef LZW_DICT_INIT_EN
            ST_INIT: begin
                cs_c       = 1'b1;
                we_c       = 1'b1;
                drv_c      = 1'b1;
                addr_c     = init_cnt_q;
                drv_dat_c  = {{PREFIX_W{1'b1}}, init_cnt_q[CHAR_WIDTH-1:0]};
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_INIT) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, allocator and response registers; reset drops any access in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            code_q      <= '0;
            wdat_q      <= '0;
            rsp_code_q  <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            next_code_q <= FIRST_CODE_W;
`ifdef LZW_DICT_INIT_EN
            init_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            wdat_q      <= wdat_d;
            rsp_code_q  <= rsp_code_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            next_code_q <= next_code_d;
`ifdef LZW_DICT_INIT_EN
            init_cnt_q  <= init_cnt_d;
`endif
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RSP);
    assign rsp_code  = rsp_code_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign next_code = next_code_q;
    assign dict_full = full_c;

    assign ram_cs   = cs_c;
    assign ram_we   = we_c;
    assign ram_oe   = oe_c;
    assign ram_addr = addr_c;
    // Bus is only driven during writes, never while the RAM has oe asserted
    assign ram_data = drv_c ? drv_dat_c : 'z;

endmodule

// File: tb/tb_lzw_dict_ctrl.sv
// Directed bench for lzw_dict_ctrl with a behavioural sync single-port RAM.
module tb_lzw_dict_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [11:0] req_code;
    logic [19:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [11:0] rsp_code;
    logic [19:0] rsp_data;
    logic        rsp_err;
    logic [12:0] next_code;
    logic        dict_full;
    logic [11:0] ram_addr;
    wire  [19:0] ram_data;
    logic        ram_cs, ram_we, ram_oe;

    always #5 clk = ~clk;

    lzw_dict_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_code  (req_code),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_code  (rsp_code),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .next_code (next_code),
        .dict_full (dict_full),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe)
    );

    // Behavioural RAM: sync write, sync read into an output register that drives under oe
    logic [19:0] mem [0:4095];
    logic [19:0] ram_rd_q;
    int cs_cnt = 0, we_cnt = 0, oe_cnt = 0;

    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
        else if (ram_cs) ram_rd_q <= mem[ram_addr];
        if (ram_cs) cs_cnt <= cs_cnt + 1;
        if (ram_we) we_cnt <= we_cnt + 1;
        if (ram_oe) oe_cnt <= oe_cnt + 1;
    end
    assign ram_data = ram_oe ? ram_rd_q : 'z;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Result of the most recent transaction
    int          lat;
    logic        r_vld;
    logic [11:0] r_code;
    logic [19:0] r_data;
    logic        r_err;

    // Issue one request at a negedge in IDLE, wait (bounded) for rsp_valid,
    // optionally stall rsp_ready for `hold` cycles checking stability, then consume.
    task automatic xact(input logic [1:0] op, input logic [11:0] code,
                        input logic [19:0] data, input int hold);
        req_valid = 1'b1;
        req_op    = op;
        req_code  = code;
        req_data  = data;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
        end while (!rsp_valid && lat < 20);
        r_vld  = rsp_valid;
        r_code = rsp_code;
        r_data = rsp_data;
        r_err  = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_vld",   rsp_valid, 1'b1);
            check("hold_rdy",   req_ready, 1'b0);
            check("hold_code",  rsp_code,  r_code);
            check("hold_data",  rsp_data,  r_data);
            check("hold_err",   rsp_err,   r_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    int cs0, we0, oe0, bad, k;
`ifdef LZW_DICT_INIT_EN
    localparam int LIT_LAT = 3;
`else
    localparam int LIT_LAT = 1;
`endif

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_code = '0; req_data = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rsp_vld", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_code", rsp_code, 12'h0);
        check("rst_rsp_data", rsp_data, 20'h0);
        check("rst_next_code", next_code, 13'd256);
        check("rst_dict_full", dict_full, 1'b0);
        check("rst_ram_cs", {ram_cs, ram_we, ram_oe}, 3'b000);
        check("rst_ram_addr", ram_addr, 12'h0);
`ifdef LZW_DICT_INIT_EN
        check("rst_req_rdy", req_ready, 1'b0);
        rst_n = 1'b1;
        k = 0;
        while (!req_ready && k < 400) begin @(negedge clk); k++; end
        check("init_cycles", k, 256);
`else
        check("rst_req_rdy", req_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        // Insert 0x12345 -> code 256
        we0 = we_cnt;
        check("ins_rdy", req_ready, 1'b1);
        xact(2'b01, 12'h0, 20'h12345, 0);
        check("ins_lat", lat, 2);
        check("ins_code", r_code, 12'd256);
        check("ins_err", r_err, 1'b0);
        check("ins_data", r_data, 20'h0);
        check("ins_mem", mem[256], 20'h12345);
        check("ins_next", next_code, 13'd257);
        check("ins_we", we_cnt - we0, 1);

        // RAM read of 256
        cs0 = cs_cnt; oe0 = oe_cnt;
        xact(2'b00, 12'd256, 20'h0, 0);
        check("rd_lat", lat, 3);
        check("rd_data", r_data, 20'h12345);
        check("rd_code", r_code, 12'd256);
        check("rd_err", r_err, 1'b0);
        check("rd_cs_cycles", cs_cnt - cs0, 2);
        check("rd_oe_cycles", oe_cnt - oe0, 1);

        // Literal read 0x41
        cs0 = cs_cnt;
        xact(2'b00, 12'h041, 20'h0, 0);
        check("lit_lat", lat, LIT_LAT);
        check("lit_data", r_data, 20'hFFF41);
        check("lit_err", r_err, 1'b0);
        check("lit_cs", (cs_cnt - cs0) != 0, LIT_LAT == 3);

        // Out-of-range read, response stalled for 5 cycles
        cs0 = cs_cnt;
        xact(2'b00, 12'd300, 20'h0, 5);
        check("oor_lat", lat, 1);
        check("oor_err", r_err, 1'b1);
        check("oor_code", r_code, 12'd300);
        check("oor_cs", cs_cnt - cs0, 0);

        // Reserved op
        xact(2'b11, 12'd5, 20'h0, 0);
        check("rsvd_err", r_err, 1'b1);
        check("rsvd_next", next_code, 13'd257);

        // Fill 257..4095
        bad = 0;
        for (int c = 257; c < 4096; c++) begin
            xact(2'b01, 12'h0, 20'(c * 3 + 1), 0);
            if (r_code != 12'(c) || r_err || lat != 2) bad++;
        end
        check("fill_rsps", bad, 0);
        check("fill_mem", mem[4095], 20'(4095 * 3 + 1));
        check("fill_next", next_code, 13'd4096);
        check("fill_full", dict_full, 1'b1);

        // Insert when full
        we0 = we_cnt;
        xact(2'b01, 12'h0, 20'hABCDE, 0);
        check("full_err", r_err, 1'b1);
        check("full_lat", lat, 1);
        check("full_we", we_cnt - we0, 0);
        check("full_next", next_code, 13'd4096);

        // Top code is readable when full
        xact(2'b00, 12'd4095, 20'h0, 0);
        check("top_rd_data", r_data, 20'(4095 * 3 + 1));

        // Clear
        xact(2'b10, 12'h0, 20'h0, 0);
        check("clr_err", r_err, 1'b0);
        check("clr_lat", lat, 1);
        check("clr_next", next_code, 13'd256);
        check("clr_full", dict_full, 1'b0);

        // Reallocate after clear
        xact(2'b01, 12'h0, 20'h0BEEF, 0);
        check("realloc_code", r_code, 12'd256);
        check("realloc_mem", mem[256], 20'h0BEEF);

        // Reset during RD_CAPTURE
        req_valid = 1'b1; req_op = 2'b00; req_code = 12'd256;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_capture", ram_oe, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_vld", rsp_valid, 1'b0);
        check("abort_cs", {ram_cs, ram_oe}, 2'b00);
        check("abort_next", next_code, 13'd256);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
